// File: rtl/audio_pkg.sv
// Shared types and constants for the PCM flash streamer.
package audio_pkg;

  localparam int CLK_DIV_44K1 = 1134;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/audio_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled, tick on the terminal count.
// Zero latency from count to tick; no backpressure.
module audio_tick_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_44K1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = en && (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/audio_stream_fetcher.sv
// Streams NUM_CH x SAMPLE_BYTES frames from byte-wide flash into a shadow register,
// committing to audio_out only on the sample tick; stop > start > tick.
module audio_stream_fetcher
  import audio_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_BYTES = 2,
  parameter int CLK_DIV      = CLK_DIV_44K1,
  parameter int WAIT_CYCLES  = 6,
  parameter bit BIG_ENDIAN   = 1'b1,
  parameter bit CFG_CHECK    = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             loop_en,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [ADDR_W-1:0]                num_frames,
  input  logic [7:0]                       flash_data,
  output logic [ADDR_W-1:0]                flash_addr,
  output logic                             flash_rd,
  output logic [NUM_CH*SAMPLE_BYTES*8-1:0] audio_out,
  output logic                             sample_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             underrun
);

  localparam int FB   = NUM_CH * SAMPLE_BYTES;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SB_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam int WT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit CFG_OK = (FB * WAIT_CYCLES < CLK_DIV);

  state_t            state;
  logic [ADDR_W-1:0] base_lat;
  logic [ADDR_W-1:0] num_lat;
  logic [ADDR_W-1:0] frame_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [SB_W-1:0]   sb_cnt;
  logic [WT_W-1:0]   wait_cnt;
  logic [FB*8-1:0]   shadow;
  logic              shadow_full;
  logic              tick;
  logic              start_ok;
  logic              byte_done;
  logic              last_byte;
  logic              last_frame;
  int                byte_pos;

  assign start_ok   = start && (num_frames != '0);
  assign byte_done  = (wait_cnt == WT_W'(WAIT_CYCLES - 1));
  assign last_byte  = (ch_cnt == CH_W'(NUM_CH - 1)) && (sb_cnt == SB_W'(SAMPLE_BYTES - 1));
  assign last_frame = (frame_cnt == num_lat - ADDR_W'(1));
  assign busy       = (state != IDLE);
  assign flash_rd   = (state == FETCH);

  // Byte position inside the shadow word; ch0 occupies the low bytes.
  always_comb begin
    byte_pos = int'(ch_cnt) * SAMPLE_BYTES
             + (BIG_ENDIAN ? (SAMPLE_BYTES - 1 - int'(sb_cnt)) : int'(sb_cnt));
  end

  audio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok || !busy),
    .en      (busy),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      base_lat     <= '0;
      num_lat      <= '0;
      frame_cnt    <= '0;
      ch_cnt       <= '0;
      sb_cnt       <= '0;
      wait_cnt     <= '0;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      flash_addr   <= '0;
      audio_out    <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        shadow_full <= 1'b0;
      end else if (start_ok) begin
        state       <= FETCH;
        base_lat    <= base_addr;
        num_lat     <= num_frames;
        frame_cnt   <= '0;
        flash_addr  <= base_addr;
        ch_cnt      <= '0;
        sb_cnt      <= '0;
        wait_cnt    <= '0;
        shadow_full <= 1'b0;
      end else if (state == FETCH) begin
        // A tick that lands mid-fetch is reported and skipped; the frame commits next tick.
        if (tick) underrun <= 1'b1;
        if (byte_done) begin
          shadow[byte_pos*8 +: 8] <= flash_data;
          wait_cnt <= '0;
          if (last_byte) begin
            ch_cnt      <= '0;
            sb_cnt      <= '0;
            shadow_full <= 1'b1;
            state       <= WAIT;
          end else begin
            flash_addr <= flash_addr + ADDR_W'(1);
            if (sb_cnt == SB_W'(SAMPLE_BYTES - 1)) begin
              sb_cnt <= '0;
              ch_cnt <= ch_cnt + CH_W'(1);
            end else begin
              sb_cnt <= sb_cnt + SB_W'(1);
            end
          end
        end else begin
          wait_cnt <= wait_cnt + WT_W'(1);
        end
      end else if (state == WAIT && tick && shadow_full) begin
        audio_out    <= shadow;
        sample_valid <= 1'b1;
        shadow_full  <= 1'b0;
        if (!last_frame) begin
          frame_cnt  <= frame_cnt + ADDR_W'(1);
          flash_addr <= flash_addr + ADDR_W'(1);
          state      <= FETCH;
        end else if (loop_en) begin
          frame_cnt  <= '0;
          flash_addr <= base_lat;
          state      <= FETCH;
        end else begin
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

  if (CFG_CHECK) begin : g_cfg_check
    always_ff @(posedge clk) begin
      if (reset_n) assert (CFG_OK);
    end
  end

endmodule

// File: tb/tb_audio_stream_fetcher.sv
// Directed bench: three parameterisations share stimulus, each with a flash model data = addr[7:0].
module tb_audio_stream_fetcher;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, loop_en;
  logic [AW-1:0] base_addr, num_frames;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  logic [AW-1:0] be_fa, le_fa, fs_fa;
  logic [7:0]    be_fd, le_fd, fs_fd;
  logic [31:0]   be_audio, le_audio, fs_audio;
  logic          be_rd, be_sv, be_busy, be_done, be_ur;
  logic          le_rd, le_sv, le_busy, le_done, le_ur;
  logic          fs_rd, fs_sv, fs_busy, fs_done, fs_ur;

  assign be_fd = be_fa[7:0];
  assign le_fd = le_fa[7:0];
  assign fs_fd = fs_fa[7:0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_stream_fetcher u_be (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .base_addr(base_addr), .num_frames(num_frames), .flash_data(be_fd),
    .flash_addr(be_fa), .flash_rd(be_rd), .audio_out(be_audio), .sample_valid(be_sv),
    .busy(be_busy), .done(be_done), .underrun(be_ur)
  );

  audio_stream_fetcher #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .base_addr(base_addr), .num_frames(num_frames), .flash_data(le_fd),
    .flash_addr(le_fa), .flash_rd(le_rd), .audio_out(le_audio), .sample_valid(le_sv),
    .busy(le_busy), .done(le_done), .underrun(le_ur)
  );

  audio_stream_fetcher #(.CLK_DIV(20), .WAIT_CYCLES(6), .CFG_CHECK(1'b0)) u_fs (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .base_addr(base_addr), .num_frames(num_frames), .flash_data(fs_fd),
    .flash_addr(fs_fa), .flash_rd(fs_rd), .audio_out(fs_audio), .sample_valid(fs_sv),
    .busy(fs_busy), .done(fs_done), .underrun(fs_ur)
  );

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n, output int t0);
    @(posedge clk); #1;
    base_addr = b; num_frames = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_stop;
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
  endtask

  // Returns at the negedge where the selected instance shows sample_valid, or after limit cycles.
  task automatic wait_sv(input int which, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && be_sv) || (which == 1 && le_sv) || (which == 2 && fs_sv)) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    base_addr = '0; num_frames = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({be_audio, be_fa, be_rd, be_sv, be_busy, be_done, be_ur} !== '0) begin
      failures++;
      $display("FAIL reset_state audio=%h addr=%h rd=%b sv=%b busy=%b done=%b ur=%b, all required 0",
               be_audio, be_fa, be_rd, be_sv, be_busy, be_done, be_ur);
    end
    #2 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (be_busy !== 1'b0 || fs_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b/%b required 0/0", be_busy, fs_busy);
    end
  endtask

  task automatic test_playback;
    int t0;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h1213_1011; exp_a[1] = 32'h1617_1415; exp_a[2] = 32'h1a1b_1819;
    pulse_start(22'h10, 22'd3, t0);
    for (int f = 0; f < 3; f++) begin
      wait_sv(0, 1500);
      checks++;
      if (cyc - t0 !== 1134 * (f + 1)) begin
        failures++;
        $display("FAIL play_latency frame %0d got %0d cycles required %0d", f, cyc - t0, 1134 * (f + 1));
      end
      checks++;
      if (be_audio !== exp_a[f]) begin
        failures++;
        $display("FAIL play_data frame %0d got %h required %h", f, be_audio, exp_a[f]);
      end
      checks++;
      if (be_done !== (f == 2) || be_busy !== (f != 2)) begin
        failures++;
        $display("FAIL play_done frame %0d done=%b busy=%b required %b/%b", f, be_done, be_busy, f == 2, f != 2);
      end
    end
    @(negedge clk);
    checks++;
    if (be_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b required 0", be_done);
    end
  endtask

  task automatic test_little_endian;
    int t0;
    pulse_start(22'h10, 22'd3, t0);
    wait_sv(1, 1500);
    checks++;
    if (cyc - t0 !== 1134 || le_audio !== 32'h1312_1110) begin
      failures++;
      $display("FAIL le_first latency=%0d data=%h required 1134/13121110", cyc - t0, le_audio);
    end
    pulse_stop();
  endtask

  task automatic test_underrun;
    int t0, ur_at, sv_at;
    ur_at = -1; sv_at = -1;
    pulse_start(22'h10, 22'd3, t0);
    for (int i = 0; i < 100 && sv_at < 0; i++) begin
      @(negedge clk);
      if (fs_ur && ur_at < 0) ur_at = cyc - t0;
      if (fs_sv) sv_at = cyc - t0;
    end
    checks++;
    if (ur_at !== 20) begin
      failures++;
      $display("FAIL underrun_tick got %0d required 20", ur_at);
    end
    checks++;
    if (sv_at !== 40 || fs_audio !== 32'h1213_1011) begin
      failures++;
      $display("FAIL underrun_commit at=%0d data=%h required 40/12131011", sv_at, fs_audio);
    end
    pulse_stop();
  endtask

  task automatic test_loop;
    int t0;
    logic [31:0] exp_a [2];
    logic [AW-1:0] exp_fa [2];
    exp_a[0] = 32'h4243_4041; exp_a[1] = 32'h4647_4445;
    exp_fa[0] = 22'h44; exp_fa[1] = 22'h40;
    loop_en = 1'b1;
    pulse_start(22'h40, 22'd2, t0);
    for (int f = 0; f < 4; f++) begin
      wait_sv(0, 1500);
      checks++;
      if (cyc - t0 !== 1134 * (f + 1) || be_audio !== exp_a[f % 2]) begin
        failures++;
        $display("FAIL loop_commit %0d latency=%0d data=%h required %0d/%h", f, cyc - t0, be_audio, 1134 * (f + 1), exp_a[f % 2]);
      end
      checks++;
      if (be_done !== 1'b0 || be_busy !== 1'b1 || be_fa !== exp_fa[f % 2]) begin
        failures++;
        $display("FAIL loop_state %0d done=%b busy=%b addr=%h required 0/1/%h", f, be_done, be_busy, be_fa, exp_fa[f % 2]);
      end
    end
    pulse_stop();
    loop_en = 1'b0;
  endtask

  task automatic test_stop_restart;
    int t0, events;
    pulse_start(22'h10, 22'd3, t0);
    wait_sv(0, 1500);
    repeat (5) @(negedge clk);
    checks++;
    if (be_rd !== 1'b1) begin
      failures++;
      $display("FAIL stop_precond flash_rd=%b required 1", be_rd);
    end
    pulse_stop();
    @(negedge clk);
    checks++;
    if (be_rd !== 1'b0 || be_busy !== 1'b0 || be_audio !== 32'h1213_1011 || be_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_effect rd=%b busy=%b audio=%h done=%b required 0/0/12131011/0", be_rd, be_busy, be_audio, be_done);
    end
    events = 0;
    repeat (50) begin
      @(negedge clk);
      if (be_sv || be_done || be_busy) events++;
    end
    checks++;
    if (events !== 0) begin
      failures++;
      $display("FAIL stop_quiet activity=%0d required 0", events);
    end
    pulse_start(22'h80, 22'd1, t0);
    wait_sv(0, 1500);
    checks++;
    if (cyc - t0 !== 1134 || be_audio !== 32'h8283_8081 || be_done !== 1'b1) begin
      failures++;
      $display("FAIL restart latency=%0d data=%h done=%b required 1134/82838081/1", cyc - t0, be_audio, be_done);
    end
  endtask

  task automatic test_async_reset;
    int t0, bad;
    pulse_start(22'h20, 22'd2, t0);
    wait_sv(0, 1500);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({be_audio, be_fa, be_rd, be_sv, be_busy, be_done, be_ur} !== '0) begin
      failures++;
      $display("FAIL async_reset audio=%h addr=%h rd=%b busy=%b required all 0", be_audio, be_fa, be_rd, be_busy);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    pulse_start(22'h20, 22'd0, t0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (be_busy || be_rd || fs_busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL zero_frames busy_cycles=%0d required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_little_endian();
    test_underrun();
    test_loop();
    test_stop_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
